// File: rtl/cpu_subsys_sram_ws_if.sv
// ---------------------------------------------------------------------------
// cpu_subsys_sram_ws_if
// CPU native memory bus (valid/ready with byte strobes) between the CPU bus
// interconnect and the on-chip SRAM.
//
// Signals:
//   mem_valid      request valid, held by the master until mem_ready
//   mem_ready      one-cycle response strobe from the SRAM
//   mem_addr       32-bit byte address, bits [1:0] ignored by the SRAM
//   mem_wdata      32-bit write data
//   mem_wstrb      4-bit byte write enables, 4'b0000 means read
//   mem_rdata      32-bit read data, valid only while mem_ready=1
//   mem_err        error qualifier, valid only while mem_ready=1
//   parity_inject  only with CPU_SUBSYS_SRAM_PARITY_EN: invert stored parity
//
// Modports: master (CPU / interconnect side), slave (SRAM side).
// Optional feature macro: CPU_SUBSYS_SRAM_PARITY_EN
// ---------------------------------------------------------------------------
interface cpu_subsys_sram_ws_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_err;
`ifdef CPU_SUBSYS_SRAM_PARITY_EN
    logic        parity_inject;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb, parity_inject,
        input  mem_ready, mem_rdata, mem_err
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb, parity_inject,
        output mem_ready, mem_rdata, mem_err
    );
`else
    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata, mem_err
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata, mem_err
    );
`endif
endinterface

// File: rtl/cpu_subsys_sram_ws.sv
// ---------------------------------------------------------------------------
// cpu_subsys_sram_ws
// Parametrised single-port 32-bit word SRAM on the CPU native memory bus with
// a registered read port (block-RAM friendly), base-address decode with an
// error flag, and a configurable number of wait states before mem_ready.
//
// Ports:
//   clk   clock, all state on the rising edge
//   rst   asynchronous reset, active-high
//   bus   cpu_subsys_sram_ws_if.slave (valid/ready/addr/wdata/wstrb/rdata/err)
//
// Parameters:
//   ADDR_WIDTH   word-address bits, DEPTH = 2**ADDR_WIDTH words
//   BASE_ADDR    byte base address, aligned to 4*DEPTH
//   WAIT_STATES  extra cycles before mem_ready (0..15)
//   INIT_FILE    initial image name (not loaded by this model)
//
// Optional feature macro: CPU_SUBSYS_SRAM_PARITY_EN
//   When defined the array stores one even-parity bit per byte; a mismatch on
//   read raises mem_err while the raw data is still returned.
// ---------------------------------------------------------------------------
module cpu_subsys_sram_ws #(
    parameter int          ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_subsys_sram_ws_if.slave   bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef CPU_SUBSYS_SRAM_PARITY_EN
    localparam int WORD_W = 36;
`else
    localparam int WORD_W = 32;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              is_write_q, is_write_d;
    logic              in_range_q, in_range_d;

    logic [WORD_W-1:0] ram [DEPTH];
    logic [WORD_W-1:0] rd_word_q;

    logic [ADDR_WIDTH-1:0] idx;
    logic                  addr_hit;
    logic                  capture;
    logic                  par_err;

    assign idx      = bus.mem_addr[ADDR_WIDTH+1:2];
    assign addr_hit = (bus.mem_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    // Gated with rst so a request held through reset cannot touch the array.
    assign capture  = (state_q == ST_IDLE) && bus.mem_valid && !rst;

    // Array and registered read port; contents are deliberately never reset.
    // The read captures the old word before the strobed bytes are updated.
    always_ff @(posedge clk) begin
        if (capture && addr_hit) begin
            rd_word_q <= ram[idx];
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wstrb[b]) begin
                    ram[idx][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
`ifdef CPU_SUBSYS_SRAM_PARITY_EN
                    ram[idx][32+b] <= (^bus.mem_wdata[8*b +: 8]) ^ bus.parity_inject;
`endif
                end
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            is_write_q <= 1'b0;
            in_range_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            in_range_q <= in_range_d;
        end
    end

    // Next state: the request is latched in IDLE, then the wait counter runs
    // down to 1 before the single response cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        in_range_d = in_range_q;
        unique case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    is_write_d = |bus.mem_wstrb;
                    in_range_d = addr_hit;
                    cnt_d      = 4'(WAIT_STATES);
                    state_d    = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Even parity over each stored byte plus its parity bit must be zero.
    always_comb begin
        par_err = 1'b0;
`ifdef CPU_SUBSYS_SRAM_PARITY_EN
        for (int b = 0; b < 4; b++) begin
            par_err = par_err | (^{rd_word_q[32+b], rd_word_q[8*b +: 8]});
        end
`endif
    end

    // Outputs are forced to zero outside the response cycle.
    always_comb begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        bus.mem_err   = 1'b0;
        if (state_q == ST_RESP) begin
            bus.mem_ready = 1'b1;
            bus.mem_err   = !in_range_q || (!is_write_q && par_err);
            if (in_range_q && !is_write_q) begin
                bus.mem_rdata = rd_word_q[31:0];
            end
        end
    end

endmodule

// File: tb/tb_cpu_subsys_sram_ws.sv
// ---------------------------------------------------------------------------
// tb_cpu_subsys_sram_ws
// Self-checking bench for cpu_subsys_sram_ws. Two instances are exercised:
//   inst 0: ADDR_WIDTH=12, BASE_ADDR=0x0000_0000, WAIT_STATES=0
//   inst 1: ADDR_WIDTH=6,  BASE_ADDR=0x0000_1000, WAIT_STATES=3
// A word-level memory model (associative arrays) predicts read data, error
// flags and the response latency of 1+WAIT_STATES cycles.
// Optional feature macro: CPU_SUBSYS_SRAM_PARITY_EN
// ---------------------------------------------------------------------------
module tb_cpu_subsys_sram_ws;

    localparam int          AW0   = 12;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam int          WS0   = 0;
    localparam int          AW1   = 6;
    localparam logic [31:0] BASE1 = 32'h0000_1000;
    localparam int          WS1   = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cpu_subsys_sram_ws_if if0 ();
    cpu_subsys_sram_ws_if if1 ();

    cpu_subsys_sram_ws #(
        .ADDR_WIDTH (AW0),
        .BASE_ADDR  (BASE0),
        .WAIT_STATES(WS0),
        .INIT_FILE  ("")
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(if0.slave)
    );

    cpu_subsys_sram_ws #(
        .ADDR_WIDTH (AW1),
        .BASE_ADDR  (BASE1),
        .WAIT_STATES(WS1),
        .INIT_FILE  ("")
    ) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(if1.slave)
    );

    int passed = 0;
    int total  = 0;

    // Model: key = sel<<24 | word offset from base.
    logic [31:0] model_mem    [int];
    logic [3:0]  model_poison [int];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    task automatic drive(input int sel, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic inj);
        if (sel == 0) begin
            if0.mem_valid = v;
            if0.mem_addr  = a;
            if0.mem_wdata = d;
            if0.mem_wstrb = s;
`ifdef CPU_SUBSYS_SRAM_PARITY_EN
            if0.parity_inject = inj;
`endif
        end else begin
            if1.mem_valid = v;
            if1.mem_addr  = a;
            if1.mem_wdata = d;
            if1.mem_wstrb = s;
`ifdef CPU_SUBSYS_SRAM_PARITY_EN
            if1.parity_inject = inj;
`endif
        end
        if (inj) begin end
    endtask

    task automatic sample(input int sel, output logic r, output logic [31:0] rd, output logic e);
        if (sel == 0) begin
            r  = if0.mem_ready;
            rd = if0.mem_rdata;
            e  = if0.mem_err;
        end else begin
            r  = if1.mem_ready;
            rd = if1.mem_rdata;
            e  = if1.mem_err;
        end
    endtask

    function automatic logic hit(input int sel, input logic [31:0] addr);
        longint base = (sel == 0) ? longint'(BASE0) : longint'(BASE1);
        longint span = (sel == 0) ? (longint'(4) << AW0) : (longint'(4) << AW1);
        longint a    = longint'(addr & 32'hFFFF_FFFC);
        return (a >= base) && (a < base + span);
    endfunction

    function automatic int key_of(input int sel, input logic [31:0] addr);
        logic [31:0] base = (sel == 0) ? BASE0 : BASE1;
        return (sel << 24) | int'(((addr & 32'hFFFF_FFFC) - base) >> 2);
    endfunction

    // One complete access starting in an IDLE cycle (caller sits 1 time unit
    // after a rising edge). Address/data are scrambled after the capture edge
    // and mem_valid may be dropped early; neither may affect the result.
    task automatic applyStimulus(input int sel, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input logic hold, input logic inj);
        int          ws = (sel == 0) ? WS0 : WS1;
        logic        in_rng = hit(sel, addr);
        int          k = key_of(sel, addr);
        logic [31:0] exp_rdata = 32'h0;
        logic        exp_err = !in_rng;
        logic        known = 1'b1;
        logic [31:0] word;
        logic        r, e;
        logic [31:0] rd;
        int          lat = 0;
        logic        got = 1'b0;

        if (in_rng && wstrb == 4'h0) begin
            if (model_mem.exists(k)) begin
                exp_rdata = model_mem[k];
                exp_err   = (model_poison[k] != 4'h0);
            end else begin
                known = 1'b0;
            end
        end
        if (in_rng && wstrb != 4'h0) begin
            word = model_mem.exists(k) ? model_mem[k] : 32'h0;
            if (!model_poison.exists(k)) model_poison[k] = 4'h0;
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    word[8*b +: 8]     = wdata[8*b +: 8];
                    model_poison[k][b] = inj;
                end
            end
            model_mem[k] = word;
        end

        drive(sel, 1'b1, addr, wdata, wstrb, inj);
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            sample(sel, r, rd, e);
            if (r) begin
                got = 1'b1;
                drive(sel, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
            end else begin
                checkOutput("rdata_while_not_ready", rd, 32'h0);
                checkOutput("err_while_not_ready", {31'h0, e}, 32'h0);
                drive(sel, hold, $urandom, $urandom, 4'($urandom), 1'b0);
            end
        end
        checkOutput("latency", lat, 1 + ws);
        if (known) checkOutput("rdata", rd, exp_rdata);
        checkOutput("err", {31'h0, e}, {31'h0, exp_err});
        @(posedge clk); #1;
        sample(sel, r, rd, e);
        checkOutput("ready_one_cycle", {31'h0, r}, 32'h0);
    endtask

    initial begin
        logic        r, e;
        logic [31:0] rd;
        logic [31:0] a, d;
        logic [3:0]  s;
        int          sel;

        rst = 1'b1;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            sample(i, r, rd, e);
            checkOutput("reset_ready", {31'h0, r}, 32'h0);
            checkOutput("reset_rdata", rd, 32'h0);
            checkOutput("reset_err", {31'h0, e}, 32'h0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Full-word write then read back, zero wait states.
        applyStimulus(0, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0);
        applyStimulus(0, 32'h0000_0000, 32'h0, 4'h0, 1'b1, 1'b0);

        // Byte strobes merge into the existing word.
        applyStimulus(0, 32'h0000_0010, 32'h1122_3344, 4'hF, 1'b1, 1'b0);
        applyStimulus(0, 32'h0000_0010, 32'hAABB_CCDD, 4'b0101, 1'b1, 1'b0);
        applyStimulus(0, 32'h0000_0013, 32'h0, 4'h0, 1'b1, 1'b0);

        // Three wait states on instance 1.
        applyStimulus(1, BASE1 + 32'h4, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0);
        applyStimulus(1, BASE1 + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0);

        // Out-of-range accesses, including just past the top and below base.
        applyStimulus(0, 32'h0000_4000, 32'h5555_AAAA, 4'hF, 1'b1, 1'b0);
        applyStimulus(0, 32'h0000_0000, 32'h0, 4'h0, 1'b1, 1'b0);
        applyStimulus(1, BASE1 - 32'h4, 32'h1234_5678, 4'hF, 1'b1, 1'b0);
        applyStimulus(1, BASE1 + 32'h100, 32'h0, 4'h0, 1'b0, 1'b0);
        applyStimulus(1, BASE1 + 32'hFC, 32'h0BAD_C0DE, 4'hF, 1'b0, 1'b0);
        applyStimulus(1, BASE1 + 32'hFC, 32'h0, 4'h0, 1'b1, 1'b0);

        // Reset during WAIT of a write: no response, but the write is kept.
        a = BASE1 + 32'h8;
        d = 32'h8765_4321;
        drive(1, 1'b1, a, d, 4'hF, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        sample(1, r, rd, e);
        checkOutput("ready_in_reset", {31'h0, r}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        model_mem[key_of(1, a)]    = d;
        model_poison[key_of(1, a)] = 4'h0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            sample(1, r, rd, e);
            checkOutput("no_resp_after_reset", {31'h0, r}, 32'h0);
        end
        applyStimulus(1, a, 32'h0, 4'h0, 1'b1, 1'b0);

        // Reset while mem_ready is high drops it immediately.
        drive(0, 1'b1, 32'h0000_0010, 32'h0, 4'h0, 1'b0);
        @(posedge clk); #1;
        sample(0, r, rd, e);
        checkOutput("ready_before_reset", {31'h0, r}, 32'h1);
        rst = 1'b1;
        #1;
        sample(0, r, rd, e);
        checkOutput("ready_drop_on_reset", {31'h0, r}, 32'h0);
        checkOutput("rdata_drop_on_reset", rd, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        @(posedge clk); #1;

`ifdef CPU_SUBSYS_SRAM_PARITY_EN
        // Poisoned parity reports an error but still returns raw data.
        applyStimulus(0, 32'h0000_000C, 32'h0F0F_1234, 4'hF, 1'b1, 1'b1);
        applyStimulus(0, 32'h0000_000C, 32'h0, 4'h0, 1'b1, 1'b0);
        applyStimulus(0, 32'h0000_000C, 32'h0F0F_1234, 4'hF, 1'b1, 1'b0);
        applyStimulus(0, 32'h0000_000C, 32'h0, 4'h0, 1'b1, 1'b0);
`endif

        // Prefill a small pool per instance, then random traffic on it.
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 8; w++) begin
                applyStimulus(i, ((i == 0) ? BASE0 : BASE1) + 32'h40 + 32'(4 * w),
                              $urandom, 4'hF, 1'b1, 1'b0);
            end
        end
        for (int n = 0; n < 80; n++) begin
            sel = n % 2;
            if ($urandom_range(0, 9) == 0) begin
                a = $urandom;
            end else begin
                a = ((sel == 0) ? BASE0 : BASE1) + 32'h40
                    + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            end
            s = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
            if (hit(sel, a) && !model_mem.exists(key_of(sel, a)) && s != 4'h0) s = 4'hF;
            applyStimulus(sel, a, $urandom, s, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
